thumb_prefetch_buffer: RTL and testbench

Instruction prefetch unit sitting directly upstream of the IF/ID instruction register in the Cortex-M0 core. It issues word-aligned reads to the program ROM and buffers the returned halfwords in a small queue. It reassembles 16-bit and 32-bit Thumb instructions, including 32-bit instructions that straddle a word boundary. Each complete instruction is presented to the decode stage with a valid/ready handshake, and a flush input redirects fetch on a branch or exception.

---
 rtl/thumb_prefetch_buffer.sv | 116 +++++++++++
 tb/tb_thumb_prefetch_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_prefetch_buffer.sv
// Thumb instruction prefetch: word fetches from program ROM into a halfword queue,
// reassembling 16/32-bit instructions (including word-straddling ones) for decode.
module thumb_prefetch_buffer #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH_HW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              rom_req,
    output logic [ADDR_W-3:0] rom_addr,
    input  logic              rom_valid,
    input  logic [31:0]       rom_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic              inst_is32,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = $clog2(DEPTH_HW + 1);

    logic [15:0]       queue [DEPTH_HW];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
    logic [CNT_W-1:0]  count;
    logic              pending, drop, skip_lo, run;
    logic [ADDR_W-3:0] fetch_word;
    logic [ADDR_W-1:0] head_pc;

    logic [15:0]       head_lo, head_hi;
    logic              head_is32, transfer, accept;
    logic [1:0]        enq_n, deq_n;
    logic [CNT_W+1:0]  occupancy;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH_HW))
            s = s - (PTR_W+1)'(DEPTH_HW);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        rd_ptr1   = ptr_add(rd_ptr, 2'd1);
        wr_ptr1   = ptr_add(wr_ptr, 2'd1);
        head_lo   = queue[rd_ptr];
        head_hi   = queue[rd_ptr1];
        head_is32 = (head_lo[15:13] == 3'b111) && (head_lo[12:11] != 2'b00);

        inst_valid = head_is32 ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
        inst       = head_is32 ? {head_lo, head_hi} : {head_lo, 16'h0000};
        inst_is32  = head_is32;
        inst_pc    = head_pc;
        rom_addr   = fetch_word;

        // Space check reserves room for the in-flight word and ignores any same-cycle dequeue.
        occupancy = (CNT_W+2)'(count) + (pending ? (CNT_W+2)'(4) : (CNT_W+2)'(2));
        rom_req   = run && !flush && (occupancy <= (CNT_W+2)'(DEPTH_HW));

        accept   = rom_valid && pending && !drop;
        enq_n    = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
        transfer = inst_valid && inst_ready;
        deq_n    = transfer ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_HW; i++)
                queue[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= 1'b0;
            drop       <= 1'b0;
            skip_lo    <= 1'b0;
            run        <= 1'b0;
            fetch_word <= '0;
            head_pc    <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= 1'b0;
            // A return landing in the flush cycle itself is already discarded here.
            drop       <= pending && !rom_valid;
            skip_lo    <= flush_pc[1];
            run        <= 1'b1;
            fetch_word <= flush_pc[ADDR_W-1:2];
            head_pc    <= flush_pc & ~ADDR_W'(1);
        end else begin
            run     <= 1'b1;
            pending <= rom_req || (pending && !rom_valid);
            if (rom_req)
                fetch_word <= fetch_word + 1'b1;
            if (rom_valid && pending) begin
                if (drop) begin
                    drop <= 1'b0;
                end else if (skip_lo) begin
                    queue[wr_ptr] <= rom_rdata[31:16];
                    skip_lo       <= 1'b0;
                end else begin
                    queue[wr_ptr]  <= rom_rdata[15:0];
                    queue[wr_ptr1] <= rom_rdata[31:16];
                end
            end
            wr_ptr <= ptr_add(wr_ptr, enq_n);
            rd_ptr <= ptr_add(rd_ptr, deq_n);
            count  <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
            if (transfer)
                head_pc <= head_pc + (head_is32 ? ADDR_W'(4) : ADDR_W'(2));
        end
    end

endmodule

// File: tb/tb_thumb_prefetch_buffer.sv
// Bench for thumb_prefetch_buffer: one-cycle ROM responder plus an instruction-stream
// reference model that walks ROM halfwords from the expected PC.
module tb_thumb_prefetch_buffer;
    localparam int ADDR_W   = 16;
    localparam int DEPTH_HW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] flush_pc = '0;
    logic              rom_req;
    logic [ADDR_W-3:0] rom_addr;
    logic              rom_valid = 1'b0;
    logic [31:0]       rom_rdata = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst;
    logic              inst_is32;
    logic [ADDR_W-1:0] inst_pc;

    logic              inject = 1'b0;
    logic [31:0]       rom_mem [0:255];
    int                checks = 0;
    int                errors = 0;

    thumb_prefetch_buffer #(.ADDR_W(ADDR_W), .DEPTH_HW(DEPTH_HW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_rdata(rom_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_is32(inst_is32), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // ROM answers every request one cycle later; inject forces an unsolicited return.
    always @(posedge clk) begin
        rom_valid <= rom_req || inject;
        rom_rdata <= rom_req ? rom_mem[rom_addr[7:0]] : 32'hDEAD_BEEF;
    end

    function automatic logic [15:0] ref_hw(input logic [15:0] pc);
        logic [31:0] w;
        w = rom_mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic ref_is32(input logic [15:0] hw);
        return hw[15:11] >= 5'b11101;
    endfunction

    function automatic logic [31:0] ref_inst(input logic [15:0] pc);
        logic [15:0] h;
        h = ref_hw(pc);
        return ref_is32(h) ? {h, ref_hw(pc + 16'd2)} : {h, 16'h0000};
    endfunction

    task automatic fill_seq();
        logic [15:0] lo;
        for (int n = 0; n < 256; n++) begin
            lo = 16'h2000 + 16'(2 * n);
            rom_mem[n] = {lo + 16'd1, lo};
        end
    endtask

    // Releases reset on a falling edge; the following cycle is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; inst_ready = 1'b0; inject = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 6;
        if (rom_req !== 1'b0)    begin errors++; $display("FAIL reset_rom_req got %b exp 0", rom_req); end
        if (rom_addr !== '0)     begin errors++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        if (inst !== '0)         begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
        if (inst_is32 !== 1'b0)  begin errors++; $display("FAIL reset_inst_is32 got %b exp 0", inst_is32); end
        if (inst_pc !== '0)      begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    endtask

    task automatic test_seq16();
        fill_seq();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== (k == 3)) begin
                errors++; $display("FAIL seq16_latency cycle %0d got %b exp %b", k, inst_valid, k == 3);
            end
        end
        for (int i = 0; i < 20; i++) begin
            checks += 3;
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq16_valid i=%0d got %b exp 1", i, inst_valid); end
            if (inst_pc !== 16'(2 * i)) begin errors++; $display("FAIL seq16_pc got %h exp %h", inst_pc, 16'(2 * i)); end
            if (inst !== {16'h2000 + 16'(i), 16'h0000}) begin
                errors++; $display("FAIL seq16_inst got %h exp %h", inst, {16'h2000 + 16'(i), 16'h0000});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_aligned32();
        int k;
        fill_seq();
        rom_mem[0] = 32'hF800_F000;
        do_reset();
        inst_ready = 1'b1;
        for (k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
        checks += 4;
        if (inst_valid !== 1'b1)    begin errors++; $display("FAIL a32_valid got %b exp 1", inst_valid); end
        if (inst !== 32'hF000_F800) begin errors++; $display("FAIL a32_inst got %h exp f000f800", inst); end
        if (inst_is32 !== 1'b1)     begin errors++; $display("FAIL a32_is32 got %b exp 1", inst_is32); end
        if (inst_pc !== 16'h0000)   begin errors++; $display("FAIL a32_pc got %h exp 0", inst_pc); end
        @(negedge clk);
        for (k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
        checks += 3;
        if (inst_pc !== 16'h0004)   begin errors++; $display("FAIL a32_next_pc got %h exp 4", inst_pc); end
        if (inst_is32 !== 1'b0)     begin errors++; $display("FAIL a32_next_is32 got %b exp 0", inst_is32); end
        if (inst !== 32'h2002_0000) begin errors++; $display("FAIL a32_next_inst got %h exp 20020000", inst); end
    endtask

    task automatic test_straddle();
        logic [15:0] exp_pc   [3] = '{16'h0000, 16'h0002, 16'h0006};
        logic [31:0] exp_inst [3] = '{32'h2000_0000, 32'hF000_F800, 32'h2001_0000};
        logic        exp_32   [3] = '{1'b0, 1'b1, 1'b0};
        int k;
        fill_seq();
        rom_mem[0] = 32'hF000_2000;
        rom_mem[1] = 32'h2001_F800;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
            checks += 3;
            if (inst_pc !== exp_pc[i])     begin errors++; $display("FAIL strad_pc got %h exp %h", inst_pc, exp_pc[i]); end
            if (inst !== exp_inst[i])      begin errors++; $display("FAIL strad_inst got %h exp %h", inst, exp_inst[i]); end
            if (inst_is32 !== exp_32[i])   begin errors++; $display("FAIL strad_is32 got %b exp %b", inst_is32, exp_32[i]); end
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        int got = 0;
        logic [15:0] exp_pc = '0;
        fill_seq();
        do_reset();
        repeat (10) begin
            @(negedge clk);
            if (rom_req) reqs++;
        end
        checks += 4;
        if (reqs != DEPTH_HW / 2) begin errors++; $display("FAIL bp_requests got %0d exp %0d", reqs, DEPTH_HW / 2); end
        if (rom_req !== 1'b0)     begin errors++; $display("FAIL bp_rom_req got %b exp 0", rom_req); end
        if (inst_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid got %b exp 1", inst_valid); end
        if (inst_pc !== 16'h0)    begin errors++; $display("FAIL bp_head_pc got %h exp 0", inst_pc); end
        inst_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (inst_valid) begin
                checks += 2;
                if (inst_pc !== exp_pc)         begin errors++; $display("FAIL bp_pc got %h exp %h", inst_pc, exp_pc); end
                if (inst !== ref_inst(exp_pc))  begin errors++; $display("FAIL bp_inst got %h exp %h", inst, ref_inst(exp_pc)); end
                exp_pc += 16'd2;
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL bp_drain_count got %0d exp 8", got); end
    endtask

    task automatic test_flush();
        int k;
        fill_seq();
        do_reset();
        inst_ready = 1'b1;
        for (k = 0; k < 10 && !rom_valid; k++) @(negedge clk);
        checks++;
        if (rom_valid !== 1'b1) begin errors++; $display("FAIL fl_no_inflight got %b exp 1", rom_valid); end
        flush = 1'b1;
        flush_pc = 16'h0102;
        #1;
        checks++;
        if (rom_req !== 1'b0) begin errors++; $display("FAIL fl_req_in_flush got %b exp 0", rom_req); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks += 3;
        if (rom_req !== 1'b1)      begin errors++; $display("FAIL fl_req_f1 got %b exp 1", rom_req); end
        if (rom_addr !== 14'h0040) begin errors++; $display("FAIL fl_addr_f1 got %h exp 0040", rom_addr); end
        if (inst_valid !== 1'b0)   begin errors++; $display("FAIL fl_valid_f1 got %b exp 0", inst_valid); end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0)   begin errors++; $display("FAIL fl_valid_f2 got %b exp 0", inst_valid); end
        @(negedge clk);
        checks += 3;
        if (inst_valid !== 1'b1)    begin errors++; $display("FAIL fl_valid_f3 got %b exp 1", inst_valid); end
        if (inst_pc !== 16'h0102)   begin errors++; $display("FAIL fl_pc_f3 got %h exp 0102", inst_pc); end
        if (inst !== 32'h2081_0000) begin errors++; $display("FAIL fl_inst_f3 got %h exp 20810000", inst); end
        @(negedge clk);
        checks += 2;
        if (inst_pc !== 16'h0104)   begin errors++; $display("FAIL fl_pc_next got %h exp 0104", inst_pc); end
        if (inst !== 32'h2082_0000) begin errors++; $display("FAIL fl_inst_next got %h exp 20820000", inst); end
    endtask

    task automatic test_reset_mid();
        fill_seq();
        do_reset();
        inst_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", inst_valid); end
        if (rom_req !== 1'b0)    begin errors++; $display("FAIL rm_rom_req got %b exp 0", rom_req); end
        if (inst_pc !== '0)      begin errors++; $display("FAIL rm_pc got %h exp 0", inst_pc); end
        if (rom_addr !== '0)     begin errors++; $display("FAIL rm_addr got %h exp 0", rom_addr); end
        @(negedge clk);
        rst = 1'b1;
        inject = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            inject = 1'b0;
            checks++;
            if (inst_valid !== (k == 3)) begin
                errors++; $display("FAIL rm_latency cycle %0d got %b exp %b", k, inst_valid, k == 3);
            end
        end
        checks += 2;
        if (inst_pc !== 16'h0000)   begin errors++; $display("FAIL rm_first_pc got %h exp 0", inst_pc); end
        if (inst !== 32'h2000_0000) begin errors++; $display("FAIL rm_first_inst got %h exp 20000000", inst); end
        @(negedge clk);
        checks++;
        if (inst !== 32'h2001_0000) begin errors++; $display("FAIL rm_second_inst got %h exp 20010000", inst); end
    endtask

    task automatic test_random();
        logic [15:0] hw_lo, hw_hi, exp_pc;
        int got = 0;
        for (int n = 0; n < 256; n++) begin
            hw_lo = 16'($urandom);
            hw_hi = 16'($urandom);
            if ($urandom_range(0, 2) != 0) hw_lo[15] = 1'b0;
            if ($urandom_range(0, 2) != 0) hw_hi[15] = 1'b0;
            rom_mem[n] = {hw_hi, hw_lo};
        end
        do_reset();
        exp_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 59) == 0);
            if (flush) begin
                case ($urandom_range(0, 3))
                    0: flush_pc = 16'hFFFA;
                    1: flush_pc = 16'hFFFD;
                    default: flush_pc = 16'($urandom_range(0, 16'h03FF));
                endcase
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (flush) begin
                checks++;
                if (rom_req !== 1'b0) begin errors++; $display("FAIL rnd_req_in_flush got %b exp 0", rom_req); end
                exp_pc = flush_pc & 16'hFFFE;
            end else if (inst_valid) begin
                checks++;
                if (inst_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc got %h exp %h", inst_pc, exp_pc); end
                if (inst_ready) begin
                    checks += 2;
                    if (inst !== ref_inst(exp_pc)) begin
                        errors++; $display("FAIL rnd_inst pc %h got %h exp %h", exp_pc, inst, ref_inst(exp_pc));
                    end
                    if (inst_is32 !== ref_is32(ref_hw(exp_pc))) begin
                        errors++; $display("FAIL rnd_is32 pc %h got %b exp %b", exp_pc, inst_is32, ref_is32(ref_hw(exp_pc)));
                    end
                    exp_pc = exp_pc + (ref_is32(ref_hw(exp_pc)) ? 16'd4 : 16'd2);
                    got++;
                end
            end
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (got < 600) begin errors++; $display("FAIL rnd_throughput got %0d exp at least 600", got); end
    endtask

    initial begin
        test_reset();
        test_seq16();
        test_aligned32();
        test_straddle();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
